// File: rtl/arrow_input_judge_pkg.sv
// Shared arrow/state codes for the arrow path, plus the press-mask to arrow-code encoder.
package arrow_input_judge_pkg;
  localparam int NUM_ARROWS_BITS = 4;
  localparam int STATE_BITS      = 2;
  localparam int ARROW_W         = NUM_ARROWS_BITS + 1;
  localparam int STATE_W         = STATE_BITS + 1;
  localparam int NUM_BTN         = 4;
  localparam int CNT_W           = 14;

  // Button bit positions inside btn_raw: {up,down,left,right}
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  localparam logic [ARROW_W-1:0] ARROW_UP         = 5'd10;
  localparam logic [ARROW_W-1:0] ARROW_DOWN       = 5'd11;
  localparam logic [ARROW_W-1:0] ARROW_LEFT       = 5'd12;
  localparam logic [ARROW_W-1:0] ARROW_RIGHT      = 5'd13;
  localparam logic [ARROW_W-1:0] ARROW_UP_DOWN    = 5'd14;
  localparam logic [ARROW_W-1:0] ARROW_UP_LEFT    = 5'd15;
  localparam logic [ARROW_W-1:0] ARROW_UP_RIGHT   = 5'd16;
  localparam logic [ARROW_W-1:0] ARROW_DOWN_LEFT  = 5'd17;
  localparam logic [ARROW_W-1:0] ARROW_DOWN_RIGHT = 5'd18;
  localparam logic [ARROW_W-1:0] ARROW_LEFT_RIGHT = 5'd19;
  localparam logic [ARROW_W-1:0] ARROW_NONE       = 5'd20;
  localparam logic [ARROW_W-1:0] ARROW_INVALID    = 5'd21;

  localparam logic [STATE_W-1:0] STATE_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] STATE_GAME  = 3'd1;
  localparam logic [STATE_W-1:0] STATE_PAUSE = 3'd2;
  localparam logic [STATE_W-1:0] STATE_OVER  = 3'd3;

  typedef struct packed {
    logic hit;
    logic miss;
  } judge_t;

  // Three or four simultaneous presses have no display code and never match.
  function automatic logic [ARROW_W-1:0] encode_arrow(input logic [NUM_BTN-1:0] m);
    logic [ARROW_W-1:0] c;
    case (m)
      4'b0000: c = ARROW_NONE;
      4'b1000: c = ARROW_UP;
      4'b0100: c = ARROW_DOWN;
      4'b0010: c = ARROW_LEFT;
      4'b0001: c = ARROW_RIGHT;
      4'b1100: c = ARROW_UP_DOWN;
      4'b1010: c = ARROW_UP_LEFT;
      4'b1001: c = ARROW_UP_RIGHT;
      4'b0110: c = ARROW_DOWN_LEFT;
      4'b0101: c = ARROW_DOWN_RIGHT;
      4'b0011: c = ARROW_LEFT_RIGHT;
      default: c = ARROW_INVALID;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/arrow_input_judge_if.sv
// Game-control / scoring bundle between the game controller and the input judge.
interface arrow_input_judge_if;
  import arrow_input_judge_pkg::*;
  logic [STATE_W-1:0] state;
  logic               new_game;
  logic [ARROW_W-1:0] expected_arrow;
  logic [CNT_W-1:0]   score;
  logic [CNT_W-1:0]   comboCount;
  logic               hit;
  logic               miss;

  modport master (output state, new_game, expected_arrow,
                  input  score, comboCount, hit, miss);
  modport slave  (input  state, new_game, expected_arrow,
                  output score, comboCount, hit, miss);
endinterface

// File: rtl/arrow_input_judge_debouncer.sv
// One button: 2-FF synchroniser then a stability counter gating changes of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic btn_db_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
      // Level flips on the Nth consecutive disagreeing sample; any agreement restarts the count.
      if (sync_q[1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign btn_db_o = db_q;
endmodule

// File: rtl/arrow_input_judge.sv
// Debounces the arrow buttons, accumulates each beat's presses and judges them against the shown arrow.
module arrow_input_judge
  import arrow_input_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCORE_MAX       = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               metronome_clk_i,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  arrow_input_judge_if.slave jif
);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(SCORE_MAX);

  logic [NUM_BTN-1:0] db;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn_raw_i[g]),
      .btn_db_o (db[g])
    );
  end

  logic [2:0]         met_q;
  logic [NUM_BTN-1:0] attempt_q;
  logic [ARROW_W-1:0] target_q;
  logic [CNT_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]   combo_q, combo_d;
  judge_t             pulse_q, pulse_d;
  logic               beat, in_game;
  logic [ARROW_W-1:0] code;

  assign beat    = met_q[1] & ~met_q[2];
  assign in_game = (jif.state == STATE_GAME);
  assign code    = encode_arrow(attempt_q | db);

  // Outcome of a judgment, applied only on a beat in STATE_GAME.
  always_comb begin
    pulse_d = '0;
    score_d = score_q;
    combo_d = combo_q;
    if (!(target_q == ARROW_NONE && code == ARROW_NONE)) begin
      if (code == target_q) begin
        pulse_d.hit = 1'b1;
        if (score_q < SAT) score_d = score_q + CNT_W'(1);
        if (combo_q < SAT) combo_d = combo_q + CNT_W'(1);
      end else begin
        pulse_d.miss = 1'b1;
        combo_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      met_q     <= '0;
      attempt_q <= '0;
      target_q  <= ARROW_NONE;
      score_q   <= '0;
      combo_q   <= '0;
      pulse_q   <= '0;
    end else begin
      met_q   <= {met_q[1:0], metronome_clk_i};
      pulse_q <= '0;
      if (jif.new_game) begin
        score_q   <= '0;
        combo_q   <= '0;
        target_q  <= ARROW_NONE;
        attempt_q <= '0;
      end else if (in_game) begin
        if (beat) begin
          pulse_q   <= pulse_d;
          score_q   <= score_d;
          combo_q   <= combo_d;
          target_q  <= jif.expected_arrow;
          // Buttons still held at the beat count toward the next window.
          attempt_q <= db;
        end else begin
          attempt_q <= attempt_q | db;
        end
      end else begin
        attempt_q <= '0;
      end
    end
  end

  assign jif.score      = score_q;
  assign jif.comboCount = combo_q;
  assign jif.hit        = pulse_q.hit;
  assign jif.miss       = pulse_q.miss;
endmodule

// File: tb/tb_arrow_input_judge.sv
// Randomized windows of button presses checked by a scoreboard against a rule-level judge model.
module tb_arrow_input_judge;
  import arrow_input_judge_pkg::*;

  localparam int DBC  = 4;
  localparam int SMAX = 9999;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       met = 1'b0;
  logic [3:0] btn = 4'b0000;

  arrow_input_judge_if jif();

  arrow_input_judge #(.DEBOUNCE_CYCLES(DBC), .SCORE_MAX(SMAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .metronome_clk_i(met),
    .btn_raw_i      (btn),
    .jif            (jif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int score;
    int combo;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         m_score = 0;
  int         m_combo = 0;
  logic [4:0] m_tgt = 5'd20;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Code from the list of pressed buttons in display order up,down,left,right.
  function automatic logic [4:0] ref_code(input logic [3:0] m);
    int pos[$];
    int base[3] = '{0, 3, 5};
    for (int b = 3; b >= 0; b--) if (m[b]) pos.push_back(3 - b);
    if (pos.size() == 0) return 5'd20;
    if (pos.size() > 2)  return 5'd21;
    if (pos.size() == 1) return 5'(10 + pos[0]);
    return 5'(14 + base[pos[0]] + (pos[1] - pos[0] - 1));
  endfunction

  task automatic model_beat(input logic [3:0] m, input logic [4:0] nxt);
    logic [4:0] c;
    exp_t e;
    c = ref_code(m);
    if (!(m_tgt == 5'd20 && c == 5'd20)) begin
      if (c == m_tgt) begin
        if (m_score < SMAX) m_score++;
        if (m_combo < SMAX) m_combo++;
        e.hit = 1'b1;
      end else begin
        m_combo = 0;
        e.hit = 1'b0;
      end
      e.score = m_score;
      e.combo = m_combo;
      sb.push_back(e);
    end
    m_tgt = nxt;
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b, input int len);
    btn[b] = 1'b1;
    clk_n(len);
    btn[b] = 1'b0;
    clk_n(8);
  endtask

  task automatic model_new_game();
    m_score = 0;
    m_combo = 0;
    m_tgt   = 5'd20;
  endtask

  // One beat window: presses (all released well before the beat), then the closing beat.
  task automatic run_window(input logic [3:0] mask, input logic [4:0] exp_a,
                            input bit game, input bit glitch, input bit ng);
    jif.state          = game ? STATE_GAME : STATE_PAUSE;
    jif.expected_arrow = exp_a;
    for (int b = 3; b >= 0; b--) if (mask[b]) press(b, 5 + int'($urandom_range(0, 6)));
    if (glitch) press(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    if (ng) begin
      jif.new_game = 1'b1;
      clk_n(1);
      jif.new_game = 1'b0;
      model_new_game();
    end
    clk_n(8);
    met = 1'b1;
    if (game) model_beat(ng ? 4'b0000 : mask, exp_a);
    clk_n(6);
    met = 1'b0;
    clk_n(4);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (jif.hit || jif.miss)) begin
        chk("hit_miss_exclusive", longint'(jif.hit && jif.miss), 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: hit=%0b miss=%0b with no judgment expected", jif.hit, jif.miss);
        end else begin
          e = sb.pop_front();
          chk("pulse_is_hit", jif.hit, e.hit);
          chk("score", jif.score, e.score);
          chk("combo", jif.comboCount, e.combo);
        end
      end
    end
  end

  initial begin : stim
    jif.state          = STATE_IDLE;
    jif.new_game       = 1'b0;
    jif.expected_arrow = ARROW_NONE;
    #1 rst_n = 1'b0;
    clk_n(3);
    chk("rst_score", jif.score, 0);
    chk("rst_combo", jif.comboCount, 0);
    chk("rst_hit", jif.hit, 0);
    chk("rst_miss", jif.miss, 0);
    rst_n = 1'b1;
    clk_n(2);

    run_window(4'b0000, ARROW_UP,      1, 0, 0);  // NONE target, no press: no pulse
    run_window(4'b1000, ARROW_UP_LEFT, 1, 0, 0);  // hit UP
    run_window(4'b1010, ARROW_DOWN,    1, 0, 0);  // hit UP_LEFT via separate presses
    run_window(4'b0100, ARROW_UP,      1, 0, 0);  // hit DOWN, combo 3
    run_window(4'b0001, ARROW_NONE,    1, 0, 0);  // RIGHT vs UP: miss, combo 0
    run_window(4'b1110, ARROW_UP,      1, 0, 0);  // invalid triple vs NONE: miss
    run_window(4'b0000, ARROW_DOWN,    1, 1, 0);  // glitch only vs UP: miss

    for (int i = 0; i < 120; i++) begin
      logic [3:0] m;
      logic [4:0] a;
      m = 4'($urandom_range(0, 15));
      a = 5'($urandom_range(10, 20));
      run_window(m, a, $urandom_range(0, 99) < 85, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0);
    end

    // new_game coinciding with a judging beat suppresses the pulse.
    run_window(4'b1000, ARROW_UP, 1, 0, 0);
    run_window(4'b1000, ARROW_UP, 1, 0, 0);
    jif.state = STATE_GAME;
    jif.expected_arrow = ARROW_UP;
    press(BTN_UP, 8);
    clk_n(8);
    met = 1'b1;
    clk_n(1);
    jif.new_game = 1'b1;
    clk_n(2);
    jif.new_game = 1'b0;
    model_new_game();
    clk_n(4);
    met = 1'b0;
    clk_n(4);
    chk("ng_beat_score", jif.score, 0);
    chk("ng_beat_combo", jif.comboCount, 0);
    chk("ng_beat_drained", sb.size(), 0);
    run_window(4'b0000, ARROW_UP, 1, 0, 0);
    run_window(4'b1000, ARROW_UP, 1, 0, 0);

    // Saturation: UP held across fast beats.
    jif.new_game = 1'b1;
    clk_n(1);
    jif.new_game = 1'b0;
    model_new_game();
    jif.expected_arrow = ARROW_UP;
    btn[BTN_UP] = 1'b1;
    clk_n(10);
    repeat (10003) begin
      met = 1'b1;
      model_beat(4'b1000, ARROW_UP);
      clk_n(2);
      met = 1'b0;
      clk_n(2);
    end
    btn[BTN_UP] = 1'b0;
    clk_n(12);
    chk("sat_drained", sb.size(), 0);
    chk("sat_score", jif.score, SMAX);
    chk("sat_combo", jif.comboCount, SMAX);

    // Asynchronous reset mid-game.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_score", jif.score, 0);
    chk("async_rst_combo", jif.comboCount, 0);
    chk("async_rst_hit", jif.hit, 0);
    chk("async_rst_miss", jif.miss, 0);
    clk_n(2);
    rst_n = 1'b1;
    sb.delete();
    model_new_game();
    clk_n(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
